// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit path: arbiter FSM encoding, frame length
// and a constant-width helper.
package uart_pkg;

  localparam int unsigned FRAME_LEN = 11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWaitDone,
    StHold
  } arb_state_e;

  // Ceiling log2, never below 1 so it can size a counter or index directly.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority pick: the search starts one above rr_ptr and wraps.
module uart_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((32'(rr_ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        winner[cand] = 1'b1;
        winner_idx   = cand;
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART_TX between NUM_REQ byte producers: round-robin grant held across a packet,
// length cap per grant and a watchdog on every wait for the transmitter.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CMD_PKT_LEN    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                          uart_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          tx_en,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          pkt_trunc
);

  localparam int unsigned IdxW  = clog2(NUM_REQ);
  localparam int unsigned ByteW = clog2(CMD_PKT_LEN + 1);
  localparam int unsigned WdW   = clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ByteW-1:0] ByteMax = ByteW'(CMD_PKT_LEN);
  localparam logic [WdW-1:0]   WdMax   = WdW'(TIMEOUT_CYCLES);
  localparam logic [IdxW-1:0]  PtrInit = IdxW'(NUM_REQ - 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]        grant_idx_q, grant_idx_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [ByteW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [WdW-1:0]         wd_cnt_q, wd_cnt_d;
  logic                   last_q, last_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   busy_q, timeout_q, timeout_d, trunc_q, trunc_d;

  logic [NUM_REQ-1:0]     win_onehot;
  logic [IdxW-1:0]        win_idx;
  logic                   win_any;
  logic [DATA_WIDTH-1:0]  req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_arbiter (
    .req        (req_valid),
    .rr_ptr     (rr_ptr_q),
    .winner     (win_onehot),
    .winner_idx (win_idx),
    .any        (win_any)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    rr_ptr_d    = rr_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    timeout_d   = 1'b0;
    trunc_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_any) begin
          state_d     = StLoad;
          grant_d     = win_onehot;
          grant_idx_d = win_idx;
          rr_ptr_d    = win_idx;
          byte_cnt_d  = '0;
          tx_data_d   = req_bytes[win_idx];
        end
      end
      StLoad: begin
        last_d   = req_last[grant_idx_q];
        wd_cnt_d = '0;
        state_d  = StWaitDone;
        if (byte_cnt_q != ByteMax) byte_cnt_d = byte_cnt_q + 1'b1;
      end
      StWaitDone: begin
        if (wd_cnt_q != WdMax) wd_cnt_d = wd_cnt_q + 1'b1;
        // tx_done wins over an expiring watchdog in the same cycle.
        if (tx_done) begin
          if (last_q) begin
            state_d = StIdle;
          end else if (byte_cnt_q == ByteMax) begin
            trunc_d = 1'b1;
            state_d = StIdle;
          end else if (req_valid[grant_idx_q]) begin
            state_d   = StLoad;
            tx_data_d = req_bytes[grant_idx_q];
          end else begin
            state_d  = StHold;
            wd_cnt_d = '0;
          end
        end else if (wd_cnt_q == WdMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StHold: begin
        if (wd_cnt_q != WdMax) wd_cnt_d = wd_cnt_q + 1'b1;
        if (req_valid[grant_idx_q]) begin
          state_d   = StLoad;
          tx_data_d = req_bytes[grant_idx_q];
        end else if (wd_cnt_q == WdMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StIdle) grant_d = '0;
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      rr_ptr_q    <= PtrInit;
      byte_cnt_q  <= '0;
      wd_cnt_q    <= '0;
      last_q      <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= (state_d != StIdle);
      timeout_q   <= timeout_d;
      trunc_q     <= trunc_d;
    end
  end

  assign tx_en       = (state_q == StLoad);
  assign req_ready   = (state_q == StLoad) ? grant_q : '0;
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;
  assign pkt_trunc   = trunc_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: queued byte producers, a fixed-latency UART_TX stand-in
// and an event log checked against hand-computed orderings and cycle offsets.
module tb_uart_tx_arbiter;

  localparam int NReq      = 4;
  localparam int DoneDelay = 10;

  logic        uart_clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic        tx_en, tx_done, busy, timeout_err, pkt_trunc;
  logic [7:0]  tx_data;

  always #5 uart_clk = ~uart_clk;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .DATA_WIDTH     (8),
    .CMD_PKT_LEN    (16),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .uart_clk    (uart_clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_en       (tx_en),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .timeout_err (timeout_err),
    .pkt_trunc   (pkt_trunc)
  );

  int cyc = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Producers: one byte queue per requester, {last, data}.
  logic [8:0] src_mem [NReq][32];
  int         src_cnt [NReq];
  int         src_rd  [NReq];
  logic [7:0] src_data [NReq];
  logic       src_valid [NReq];
  logic       src_last [NReq];

  assign req_data  = {src_data[3], src_data[2], src_data[1], src_data[0]};
  assign req_valid = {src_valid[3], src_valid[2], src_valid[1], src_valid[0]};
  assign req_last  = {src_last[3], src_last[2], src_last[1], src_last[0]};

  task automatic refresh(input int i);
    if (src_rd[i] < src_cnt[i]) begin
      src_valid[i] = 1'b1;
      src_data[i]  = src_mem[i][src_rd[i]][7:0];
      src_last[i]  = src_mem[i][src_rd[i]][8];
    end else begin
      src_valid[i] = 1'b0;
      src_last[i]  = 1'b0;
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    src_mem[i][src_cnt[i]] = {l, d};
    src_cnt[i]++;
    refresh(i);
  endtask

  // Advance a queue only after the edge that completed the handshake.
  initial begin
    logic [3:0] rdy;
    forever begin
      @(negedge uart_clk);
      rdy = req_ready;
      if (rdy != 4'b0000) begin
        @(posedge uart_clk);
        #1;
        for (int i = 0; i < NReq; i++) begin
          if (rdy[i]) begin
            src_rd[i]++;
            refresh(i);
          end
        end
      end
    end
  end

  // UART_TX stand-in: tx_done for one cycle, DoneDelay cycles after the tx_en cycle.
  bit uart_on = 1'b1;
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge uart_clk);
      if (tx_en && uart_on) begin
        repeat (DoneDelay) @(posedge uart_clk);
        #1 tx_done = 1'b1;
        @(posedge uart_clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  logic [3:0] log_g [128];
  logic [7:0] log_d [128];
  logic [3:0] log_r [128];
  int         log_c [128];
  int         log_n = 0;
  int         done_c [128];
  int         done_n = 0;
  int         trunc_c = 0, trunc_n = 0, to_c = 0, to_n = 0;

  initial begin
    forever begin
      @(negedge uart_clk);
      if (tx_en && log_n < 128) begin
        log_g[log_n] = grant;
        log_d[log_n] = tx_data;
        log_r[log_n] = req_ready;
        log_c[log_n] = cyc;
        log_n++;
      end
      if (tx_done && busy && done_n < 128) begin
        done_c[done_n] = cyc;
        done_n++;
      end
      if (pkt_trunc) begin
        trunc_c = cyc;
        trunc_n++;
      end
      if (timeout_err) begin
        to_c = cyc;
        to_n++;
      end
    end
  end

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_n < n && k < budget) begin
      @(negedge uart_clk);
      #2;
      k++;
    end
    if (log_n < n) check("wait_log", log_n, n);
  endtask

  task automatic wait_idle(input int budget, output int at);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge uart_clk);
      #2;
      k++;
    end
    at = cyc;
    if (busy) check("wait_idle", 32'(busy), 0);
  endtask

  task automatic wait_to(input int old, input int budget);
    int k;
    k = 0;
    while (to_n <= old && k < budget) begin
      @(negedge uart_clk);
      #2;
      k++;
    end
    if (to_n <= old) check("wait_timeout", to_n, old + 1);
  endtask

  task automatic do_reset();
    @(negedge uart_clk);
    rst_n = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      src_cnt[i] = 0;
      src_rd[i]  = 0;
      refresh(i);
    end
    repeat (20) @(negedge uart_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, db, t, lb;
    int g2 [6];
    int d2 [6];
    rst_n = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      src_data[i] = 8'h00;
      src_cnt[i]  = 0;
      src_rd[i]   = 0;
      refresh(i);
    end

    // Reset state
    do_reset();
    #2;
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_en", 32'(tx_en), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    check("rst_trunc", 32'(pkt_trunc), 0);

    // 1: single byte from req0
    @(posedge uart_clk);
    #1;
    b = log_n;
    db = done_n;
    t = cyc;
    push(0, 8'hA5, 1'b1);
    wait_log(b + 1, 40);
    check("t1_grant", 32'(log_g[b]), 'h1);
    check("t1_data", 32'(log_d[b]), 'hA5);
    check("t1_ready", 32'(log_r[b]), 'h1);
    check("t1_latency", log_c[b] - t, 1);
    wait_idle(40, t);
    check("t1_idle_after_done", t - done_c[db], 1);
    check("t1_bytes", log_n - b, 1);

    // 2: round-robin order with all four requesting
    do_reset();
    @(posedge uart_clk);
    #1;
    b = log_n;
    push(0, 8'h00, 1'b1);
    push(0, 8'h01, 1'b1);
    push(1, 8'h10, 1'b1);
    push(1, 8'h11, 1'b1);
    push(2, 8'h20, 1'b1);
    push(3, 8'h30, 1'b1);
    g2 = '{1, 2, 4, 8, 1, 2};
    d2 = '{'h00, 'h10, 'h20, 'h30, 'h01, 'h11};
    wait_log(b + 6, 200);
    for (int k = 0; k < 6; k++) begin
      check("t2_grant", 32'(log_g[b+k]), g2[k]);
      check("t2_data", 32'(log_d[b+k]), d2[k]);
    end
    wait_idle(40, t);

    // 3: three-byte packet from req1 while req3 waits
    do_reset();
    @(posedge uart_clk);
    #1;
    b = log_n;
    db = done_n;
    push(1, 8'h11, 1'b0);
    push(1, 8'h22, 1'b0);
    push(1, 8'h33, 1'b1);
    push(3, 8'h3C, 1'b1);
    wait_log(b + 4, 200);
    g2 = '{2, 2, 2, 8, 0, 0};
    d2 = '{'h11, 'h22, 'h33, 'h3C, 0, 0};
    for (int k = 0; k < 4; k++) begin
      check("t3_grant", 32'(log_g[b+k]), g2[k]);
      check("t3_data", 32'(log_d[b+k]), d2[k]);
    end
    check("t3_b2b_1", log_c[b+1] - done_c[db], 1);
    check("t3_b2b_2", log_c[b+2] - done_c[db+1], 1);
    check("t3_regrant", log_c[b+3] - done_c[db+2], 2);
    wait_idle(40, t);

    // 4: 20-byte unterminated packet from req2, capped at 16
    do_reset();
    @(posedge uart_clk);
    #1;
    b = log_n;
    db = done_n;
    lb = trunc_n;
    t = to_n;
    for (int j = 0; j < 20; j++) push(2, 8'(8'h40 + j), 1'b0);
    wait_log(b + 1, 20);
    @(posedge uart_clk);
    #1;
    push(0, 8'hE0, 1'b1);
    wait_log(b + 21, 400);
    for (int k = 0; k < 16; k++) begin
      check("t4_first_grant", 32'(log_g[b+k]), 4);
      check("t4_first_data", 32'(log_d[b+k]), 'h40 + k);
    end
    check("t4_other_grant", 32'(log_g[b+16]), 1);
    check("t4_other_data", 32'(log_d[b+16]), 'hE0);
    for (int k = 17; k < 21; k++) begin
      check("t4_rest_grant", 32'(log_g[b+k]), 4);
      check("t4_rest_data", 32'(log_d[b+k]), 'h40 + k - 1);
    end
    check("t4_trunc_count", trunc_n - lb, 1);
    check("t4_trunc_at", trunc_c - done_c[db+15], 1);
    wait_to(t, 60);
    check("t4_hold_timeout_at", to_c - done_c[db+20], 17);
    check("t4_hold_timeout_grant", 32'(grant), 0);

    // 5: transmitter never answers
    do_reset();
    uart_on = 1'b0;
    @(posedge uart_clk);
    #1;
    b = log_n;
    t = to_n;
    push(0, 8'h5A, 1'b1);
    wait_log(b + 1, 20);
    wait_to(t, 40);
    check("t5_timeout_at", to_c - log_c[b], 17);
    check("t5_busy", 32'(busy), 0);
    check("t5_grant", 32'(grant), 0);
    @(negedge uart_clk);
    #2;
    check("t5_pulse_width", 32'(timeout_err), 0);
    check("t5_timeout_count", to_n - t, 1);
    uart_on = 1'b1;

    // 6: reset in the middle of WAIT_DONE
    do_reset();
    @(posedge uart_clk);
    #1;
    b = log_n;
    push(2, 8'h77, 1'b1);
    wait_log(b + 1, 20);
    repeat (3) @(negedge uart_clk);
    #1;
    check("t6_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_grant", 32'(grant), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_tx_en", 32'(tx_en), 0);
    check("t6_req_ready", 32'(req_ready), 0);
    check("t6_tx_data", 32'(tx_data), 0);
    do_reset();
    @(posedge uart_clk);
    #1;
    b = log_n;
    push(0, 8'h0A, 1'b1);
    push(3, 8'h3A, 1'b1);
    wait_log(b + 2, 60);
    check("t6_first_grant", 32'(log_g[b]), 1);
    check("t6_first_data", 32'(log_d[b]), 'h0A);
    check("t6_second_grant", 32'(log_g[b+1]), 8);
    wait_idle(40, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
